number_store: RTL and testbench
===============================

// Module: number_store
// PURPOSE
//   Parametrised store of the numbers a player has entered in the memory game.
//   Adds to plain per-slot storage: append-only write pointer, per-entry valid
//   bits, duplicate/full rejection, indexed match lookup, and a timed playback
//   engine that replays stored numbers in entry order for the display path.
// PARAMETERS
//   WIDTH     10          bits per stored number
//   DEPTH     10          number of entries (>=2)
//   SHOW_CYC  25_000_000  cycles each number is shown during playback (>=1)
//   GAP_CYC   5_000_000   blank cycles between numbers (0 = no gap)
//   derived: IDXW = $clog2(DEPTH), CNTW = $clog2(DEPTH+1)
// PORTS
//   clk         in   1      clock, rising edge
//   clrn        in   1      asynchronous active-low reset
//   clear       in   1      synchronous clear of all entries and playback
//   wr_en       in   1      request append of wr_data (single-cycle strobe)
//   wr_data     in   WIDTH  number to append
//   wr_ack      out  1      1-cycle pulse, cycle after every wr_en
//   wr_code     out  2      with wr_ack: 00 ok, 01 dup, 10 full, 11 busy
//   probe       in   WIDTH  value to look up
//   exist       out  1      probe equals some valid entry (combinational)
//   exist_idx   out  IDXW   lowest matching index; 0 when !exist
//   count       out  CNTW   number of valid entries
//   full        out  1      count == DEPTH
//   play_start  in   1      start playback (accepted only when idle)
//   play_busy   out  1      playback in progress
//   play_valid  out  1      play_data is being shown
//   play_data   out  WIDTH  entry being shown; 0 when !play_valid
//   play_done   out  1      1-cycle pulse at end of playback
// BEHAVIOUR
//   - Reset (clrn=0): all valid bits, count, wr_ack, wr_code, play_* = 0;
//     FSM IDLE. Entry data contents don't-care (masked by valid).
//   - Value 0 is a legal stored number; only valid entries participate in lookup.
//   - Write: wr_en sampled at edge t. Priority busy > full > dup > ok.
//     ok: entry[count] <= wr_data, valid set, count+1, all visible at t+1.
//     dup = wr_data matches any valid entry. Rejected writes change nothing.
//     wr_ack/wr_code registered, valid exactly one cycle (t+1).
//   - exist/exist_idx combinational from probe and current entries; a write
//     accepted at edge t is visible to lookup from t+1.
//   - clear: highest priority. Same cycle as wr_en -> wr_ack with code 00 is
//     NOT issued; wr_en dropped (wr_ack=0). Same cycle as play_start -> start
//     ignored. Mid-playback: FSM -> IDLE, play_busy/play_valid 0 next cycle,
//     no play_done.
//   - Playback FSM: IDLE, SHOW, GAP, DONE.
//     IDLE: play_start & count==0 -> DONE. play_start & count>0 -> SHOW idx=0.
//     SHOW: play_valid=1, play_data=entry[idx] for exactly SHOW_CYC cycles;
//       then GAP if GAP_CYC>0, else next step directly.
//     GAP: play_valid=0 for GAP_CYC cycles.
//     after last SHOW/GAP of idx: idx==count-1 -> DONE, else idx+1 -> SHOW.
//     DONE: one cycle, play_done=1, play_busy=0 -> IDLE.
//     play_busy=1 in SHOW and GAP only. play_start while busy ignored.
//   - Latency: play_start at edge t -> play_valid from t+1; total playback
//     count*(SHOW_CYC+GAP_CYC) cycles, then play_done pulse.
//   - Writes while busy rejected (code 11), so count is stable during playback.
//   - Timer counter width sized for max(SHOW_CYC,GAP_CYC); no wrap.
// TESTING (WIDTH=4, DEPTH=4, SHOW_CYC=3, GAP_CYC=2)
//   1 reset, write 5,0,9 -> wr_code 00 each, count 3; probe 0 -> exist 1, idx 1;
//     probe 7 -> exist 0, idx 0.
//   2 write 9 again -> wr_code 01, count 3; write 2 -> 00, full=1; write 3 -> 10.
//   3 store 5,0,9; play_start -> play_data 5,5,5,-,-,0,0,0,-,-,9,9,9,-,- then
//     play_done 1 cycle; play_busy high for 15 cycles.
//   4 during playback: wr_en 6 -> code 11, count unchanged; play_start ignored.
//   5 clear during SHOW of idx 1 -> next cycle play_busy 0, count 0, exist 0,
//     no play_done; play_start with count 0 -> play_done next cycle only.
//   6 clrn low mid-playback (async) -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/number_store.sv
// number_store: append-only number store with duplicate/full rejection, probe lookup and timed playback
module number_store #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10,
  parameter int SHOW_CYC = 25_000_000,
  parameter int GAP_CYC = 5_000_000,
  localparam int IDXW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  output logic [1:0]       wr_code,
  input  logic [WIDTH-1:0] probe,
  output logic             exist,
  output logic [IDXW-1:0]  exist_idx,
  output logic [CNTW-1:0]  count,
  output logic             full,
  input  logic             play_start,
  output logic             play_busy,
  output logic             play_valid,
  output logic [WIDTH-1:0] play_data,
  output logic             play_done
);
  localparam int TMAX = SHOW_CYC > GAP_CYC ? SHOW_CYC : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid, hit, dup_v;
  logic [IDXW-1:0] idx, idx_nx;
  logic [TW-1:0] timer, timer_nx;
  logic dup, last, accept;
  assign exist = |hit;
  assign dup = |dup_v;
  assign full = count == CNTW'(DEPTH);
  assign last = CNTW'(idx) + CNTW'(1) == count;
  assign play_busy = state == SHOW || state == GAP;
  assign play_valid = state == SHOW;
  assign play_data = play_valid ? mem[idx] : '0;
  assign play_done = state == DONE;
  assign accept = wr_en && !clear && !play_busy && !full && !dup;
  // entries are filled in order, so slot i is valid while i < count; lowest hit wins
  always_comb begin
    valid = '0;
    hit = '0;
    dup_v = '0;
    exist_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      valid[i] = CNTW'(i) < count;
      hit[i] = valid[i] && mem[i] == probe;
      dup_v[i] = valid[i] && mem[i] == wr_data;
      if (hit[i]) exist_idx = IDXW'(i);
    end
  end
  // entry data needs no reset; it is masked by the valid bits
  always_ff @(posedge clk)
    if (accept) mem[count[IDXW-1:0]] <= wr_data;
  // write acknowledge, result code and entry count
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      count <= '0;
      wr_ack <= 1'b0;
      wr_code <= 2'b00;
    end else begin
      wr_ack <= wr_en && !clear;
      wr_code <= !(wr_en && !clear) ? 2'b00 : play_busy ? 2'b11 : full ? 2'b10 : dup ? 2'b01 : 2'b00;
      count <= clear ? '0 : accept ? count + CNTW'(1) : count;
    end
  // playback state register
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      idx <= '0;
      timer <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      timer <= timer_nx;
    end
  // playback sequencing: show each entry, optional blank gap, then a done pulse
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    timer_nx = timer + TW'(1);
    if (clear) begin
      state_nx = IDLE;
      idx_nx = '0;
      timer_nx = '0;
    end else
      case (state)
        IDLE: begin
          idx_nx = '0;
          timer_nx = '0;
          if (play_start) state_nx = count == '0 ? DONE : SHOW;
        end
        SHOW:
          if (timer == TW'(SHOW_CYC - 1)) begin
            timer_nx = '0;
            state_nx = GAP_CYC > 0 ? GAP : last ? DONE : SHOW;
            if (GAP_CYC == 0 && !last) idx_nx = idx + IDXW'(1);
          end
        GAP:
          if (timer == TW'(GAP_CYC - 1)) begin
            timer_nx = '0;
            state_nx = last ? DONE : SHOW;
            if (!last) idx_nx = idx + IDXW'(1);
          end
        default: begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      endcase
  end
endmodule

// File: tb/tb_number_store.sv
// tb_number_store: directed vector and sequence checks for number_store
module tb_number_store;
  logic clk = 0, clrn = 0, clear = 0, wr_en = 0, play_start = 0;
  logic [3:0] wr_data = 0, probe = 0;
  logic wr_ack, exist, full, play_busy, play_valid, play_done;
  logic [1:0] wr_code, exist_idx;
  logic [2:0] count;
  logic [3:0] play_data;
  int n_chk = 0, n_fail = 0;

  number_store #(.WIDTH(4), .DEPTH(4), .SHOW_CYC(3), .GAP_CYC(2)) dut (
    .clk(clk), .clrn(clrn), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_code(wr_code), .probe(probe), .exist(exist),
    .exist_idx(exist_idx), .count(count), .full(full), .play_start(play_start),
    .play_busy(play_busy), .play_valid(play_valid), .play_data(play_data),
    .play_done(play_done));

  always #5 clk = ~clk;

  typedef struct {
    int wr, clr, d, pr, ack, code, cnt, ex, ei, fl;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d);
    wr_en = 1;
    wr_data = 4'(d);
    step();
    wr_en = 0;
    chk($sformatf("write %0d code", d), int'(wr_code), 0);
  endtask

  int exp_d [3] = '{5, 0, 9};
  bit saw_done;

  initial begin
    v[0]  = '{1, 0, 5, 5, 1, 0, 1, 1, 0, 0};
    v[1]  = '{1, 0, 0, 0, 1, 0, 2, 1, 1, 0};
    v[2]  = '{1, 0, 9, 9, 1, 0, 3, 1, 2, 0};
    v[3]  = '{0, 0, 0, 0, 0, 0, 3, 1, 1, 0};
    v[4]  = '{0, 0, 0, 7, 0, 0, 3, 0, 0, 0};
    v[5]  = '{1, 0, 9, 9, 1, 1, 3, 1, 2, 0};
    v[6]  = '{1, 0, 2, 2, 1, 0, 4, 1, 3, 1};
    v[7]  = '{1, 0, 3, 3, 1, 2, 4, 0, 0, 1};
    v[8]  = '{1, 0, 5, 5, 1, 2, 4, 1, 0, 1};
    v[9]  = '{1, 1, 7, 5, 0, 0, 0, 0, 0, 0};
    v[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    #2;
    chk("reset count", int'(count), 0);
    chk("reset ack", int'(wr_ack), 0);
    chk("reset busy", int'(play_busy), 0);
    chk("reset done", int'(play_done), 0);
    #10 clrn = 1;
    step();
    foreach (v[i]) begin
      wr_en = v[i].wr[0];
      clear = v[i].clr[0];
      wr_data = 4'(v[i].d);
      probe = 4'(v[i].pr);
      step();
      wr_en = 0;
      clear = 0;
      chk($sformatf("vec%0d ack", i), int'(wr_ack), v[i].ack);
      chk($sformatf("vec%0d code", i), int'(wr_code), v[i].code);
      chk($sformatf("vec%0d count", i), int'(count), v[i].cnt);
      chk($sformatf("vec%0d exist", i), int'(exist), v[i].ex);
      chk($sformatf("vec%0d idx", i), int'(exist_idx), v[i].ei);
      chk($sformatf("vec%0d full", i), int'(full), v[i].fl);
    end
    wr(5); wr(0); wr(9);
    play_start = 1;
    step();
    play_start = 0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("play%0d busy", k), int'(play_busy), 1);
      chk($sformatf("play%0d valid", k), int'(play_valid), int'(k % 5 < 3));
      chk($sformatf("play%0d data", k), int'(play_data), k % 5 < 3 ? exp_d[k / 5] : 0);
      chk($sformatf("play%0d done", k), int'(play_done), 0);
      if (k == 5) begin
        chk("busy write ack", int'(wr_ack), 1);
        chk("busy write code", int'(wr_code), 3);
        chk("busy write count", int'(count), 3);
      end
      if (k == 6) chk("busy write ack pulse", int'(wr_ack), 0);
      wr_en = k == 4;
      play_start = k == 4;
      wr_data = 6;
      step();
    end
    wr_en = 0;
    play_start = 0;
    chk("play end done", int'(play_done), 1);
    chk("play end busy", int'(play_busy), 0);
    step();
    chk("play done pulse", int'(play_done), 0);
    play_start = 1;
    step();
    play_start = 0;
    for (int k = 0; k < 6; k++) step();
    chk("clear pre data", int'(play_data), 0);
    clear = 1;
    probe = 5;
    step();
    clear = 0;
    chk("clear busy", int'(play_busy), 0);
    chk("clear valid", int'(play_valid), 0);
    chk("clear count", int'(count), 0);
    chk("clear exist", int'(exist), 0);
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      saw_done |= play_done;
      step();
    end
    chk("clear no done", int'(saw_done), 0);
    play_start = 1;
    step();
    play_start = 0;
    chk("empty play done", int'(play_done), 1);
    chk("empty play busy", int'(play_busy), 0);
    step();
    chk("empty done pulse", int'(play_done), 0);
    wr(4);
    probe = 4;
    play_start = 1;
    step();
    play_start = 0;
    step();
    chk("pre-rst valid", int'(play_valid), 1);
    #2 clrn = 0;
    #1;
    chk("async busy", int'(play_busy), 0);
    chk("async valid", int'(play_valid), 0);
    chk("async data", int'(play_data), 0);
    chk("async count", int'(count), 0);
    chk("async exist", int'(exist), 0);
    #10 clrn = 1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
